axi_read_arbiter: RTL

//  Two-master to one-slave AXI4 read-channel arbiter placed in front of axi_slave_ram.

---
 rtl/axi_arb_pkg.sv | 17 +
 rtl/rr_arbiter_2.sv | 27 ++
 rtl/axi_read_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg
// Shared types and constants for the two-master AXI4 read arbiter.
//   arb_state_t     : arbiter FSM states (2-bit encoding)
//   AXI_RESP_OKAY   : AXI "OKAY" read response code
//   AXI_BURST_INCR  : AXI incrementing burst type code
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Two-requester round-robin pick, purely combinational.
//   req[1:0] : in  request lines, bit N = requester N
//   prio     : in  requester that wins when both request
//   grant    : out index of the selected requester (0 when nothing requests)
//   valid    : out at least one requester is active
module rr_arbiter_2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant,
    output logic       valid
);

    // A lone requester always wins; prio only breaks a tie.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = prio;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Two-master to one-slave AXI4 read-channel arbiter. The AR channel is granted
// round-robin; the winner owns the slave until its RLAST beat, then the arbiter
// returns to IDLE and re-arbitrates. Returned beat counts are checked against
// the latched ARLEN and any disagreement sets a sticky len_err flag.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mN_ar* (N=0,1) / s_ar*        : read address channel, master side / slave side
//   mN_r*  (N=0,1) / s_r*         : read data channel, master side / slave side
//   len_err                       : sticky beat-count error, cleared only by rst
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDRESS_WIDTH-1:0] m0_araddr,
    input  logic [7:0]               m0_arlen,
    input  logic [2:0]               m0_arsize,
    input  logic [1:0]               m0_arburst,
    input  logic                     m0_arvalid,
    output logic                     m0_arready,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    output logic [1:0]               m0_rresp,
    output logic                     m0_rlast,
    output logic                     m0_rvalid,
    input  logic                     m0_rready,

    input  logic [ADDRESS_WIDTH-1:0] m1_araddr,
    input  logic [7:0]               m1_arlen,
    input  logic [2:0]               m1_arsize,
    input  logic [1:0]               m1_arburst,
    input  logic                     m1_arvalid,
    output logic                     m1_arready,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic [1:0]               m1_rresp,
    output logic                     m1_rlast,
    output logic                     m1_rvalid,
    input  logic                     m1_rready,

    output logic [ADDRESS_WIDTH-1:0] s_araddr,
    output logic [7:0]               s_arlen,
    output logic [2:0]               s_arsize,
    output logic [1:0]               s_arburst,
    output logic                     s_arvalid,
    input  logic                     s_arready,
    input  logic [DATA_WIDTH-1:0]    s_rdata,
    input  logic [1:0]               s_rresp,
    input  logic                     s_rlast,
    input  logic                     s_rvalid,
    output logic                     s_rready,

    output logic                     len_err
);

    arb_state_t state;
    logic       prio;
    logic       grant;
    logic [7:0] len_q;
    logic [7:0] beat_cnt;

    logic       arb_grant;
    logic       arb_valid;
    logic       in_addr;
    logic       in_data;
    logic       r_hs;

    rr_arbiter_2 u_rr (
        .req   ({m1_arvalid, m0_arvalid}),
        .prio  (prio),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign in_addr = (state == ARB_ADDR);
    assign in_data = (state == ARB_DATA);
    assign r_hs    = s_rvalid & s_rready;

    // AR fields follow the latched grant; only the valid/ready pair is state-gated.
    assign s_araddr   = grant ? m1_araddr  : m0_araddr;
    assign s_arlen    = grant ? m1_arlen   : m0_arlen;
    assign s_arsize   = grant ? m1_arsize  : m0_arsize;
    assign s_arburst  = grant ? m1_arburst : m0_arburst;
    assign s_arvalid  = in_addr;
    assign m0_arready = in_addr & ~grant & s_arready;
    assign m1_arready = in_addr &  grant & s_arready;

    // Read data fans out to both masters; only the granted master sees rvalid.
    assign s_rready  = in_data & (grant ? m1_rready : m0_rready);
    assign m0_rvalid = in_data & ~grant & s_rvalid;
    assign m1_rvalid = in_data &  grant & s_rvalid;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;

    // Burst sequencer: arbitrate in IDLE, hold AR until accepted, then count
    // beats until RLAST. The burst always ends on RLAST even when the count
    // disagrees with the latched length; the disagreement only sets len_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            prio     <= 1'b0;
            grant    <= 1'b0;
            len_q    <= 8'd0;
            beat_cnt <= 8'd0;
            len_err  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_grant;
                        state <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (s_arready) begin
                        len_q    <= s_arlen;
                        beat_cnt <= 8'd0;
                        state    <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (s_rlast) begin
                            if (beat_cnt != len_q) begin
                                len_err <= 1'b1;
                            end
                            prio  <= ~grant;
                            state <= ARB_IDLE;
                        end else if (beat_cnt == len_q) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
